// File: rtl/tl_ul_pkg.sv
// tl_ul_pkg
//   Shared TileLink-UL constants and helpers for the requester slice.
//   - Opcode encodings for A (PutFullData, PutPartialData, Get) and D
//     (AccessAck, AccessAckData) channels.
//   - Source-ID field width and beat-counter width.
//   - beats_of(size): data beats of a Get response of 2^size bytes on a
//     64-bit bus (minimum one beat).
//   - full_mask(size, addr_lo): byte-enable mask covering a naturally
//     aligned 2^size-byte access within the 8-byte beat.
package tl_ul_pkg;

  localparam logic [2:0] OP_PUT_FULL        = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] OP_GET             = 3'd4;
  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

  localparam int unsigned SRC_W      = 5;
  // Largest encodable size (2^15 bytes) is 4096 beats, so 13 bits covers it.
  localparam int unsigned BEAT_CNT_W = 13;

  typedef enum logic {
    KIND_PUT = 1'b0,
    KIND_GET = 1'b1
  } req_kind_e;

  function automatic logic [BEAT_CNT_W-1:0] beats_of(input logic [3:0] size);
    logic [BEAT_CNT_W-1:0] n;
    if (size <= 4'd3) n = BEAT_CNT_W'(1);
    else              n = BEAT_CNT_W'(1) << (size - 4'd3);
    return n;
  endfunction

  function automatic logic [7:0] full_mask(input logic [3:0] size,
                                           input logic [2:0] addr_lo);
    logic [7:0] m;
    case (size)
      4'd0:    m = 8'h01 << addr_lo;
      4'd1:    m = 8'h03 << {addr_lo[2:1], 1'b0};
      4'd2:    m = 8'h0F << {addr_lo[2], 2'b00};
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tl_source_pool.sv
// tl_source_pool
//   Tracks which TileLink source IDs are in flight and what kind of request
//   (Get or Put) each one carries.
//   Ports:
//     clock, reset        clock / async active-high reset
//     i_alloc             allocate o_alloc_idx this cycle (only when o_any_free)
//     i_alloc_kind        kind recorded for the allocated source
//     i_free, i_free_idx  release a source this cycle
//     o_any_free          at least one source is free
//     o_alloc_idx         lowest-index free source
//     o_allocated         per-source allocated bitmap
//     o_kind_get          per-source kind bit (1 = Get)
//   Allocation and release both act on the registered bitmap, so a source
//   released this cycle becomes allocatable on the next one.
module tl_source_pool
  import tl_ul_pkg::*;
#(
  parameter int unsigned SOURCES = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_alloc,
  input  req_kind_e          i_alloc_kind,
  input  logic               i_free,
  input  logic [SRC_W-1:0]   i_free_idx,
  output logic               o_any_free,
  output logic [SRC_W-1:0]   o_alloc_idx,
  output logic [SOURCES-1:0] o_allocated,
  output logic [SOURCES-1:0] o_kind_get
);

  logic [SOURCES-1:0] r_allocated;
  logic [SOURCES-1:0] r_kind_get;
  logic [SRC_W-1:0]   w_alloc_idx;
  logic               w_found;

  always_comb begin
    w_alloc_idx = '0;
    w_found     = 1'b0;
    for (int unsigned i = 0; i < SOURCES; i++) begin
      if (!r_allocated[i] && !w_found) begin
        w_found     = 1'b1;
        w_alloc_idx = SRC_W'(i);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_allocated <= '0;
      r_kind_get  <= '0;
    end else begin
      for (int unsigned i = 0; i < SOURCES; i++) begin
        if (i_free && (i_free_idx == SRC_W'(i))) r_allocated[i] <= 1'b0;
        if (i_alloc && w_found && (w_alloc_idx == SRC_W'(i))) begin
          r_allocated[i] <= 1'b1;
          r_kind_get[i]  <= (i_alloc_kind == KIND_GET);
        end
      end
    end
  end

  assign o_any_free  = w_found;
  assign o_alloc_idx = w_alloc_idx;
  assign o_allocated = r_allocated;
  assign o_kind_get  = r_kind_get;

endmodule

// File: rtl/tl_ul_requester.sv
// tl_ul_requester
//   TileLink-UL client: converts a command stream into A-channel
//   Get / PutFullData / PutPartialData requests and forwards D-channel beats
//   back to the command owner, tracking outstanding sources and flagging
//   protocol violations.
//   Ports:
//     clock, reset                 clock / async active-high reset
//     cmd_*                        command in (write, addr, size, data, mask)
//     a_valid/a_ready, a_bits_*    A channel out (registered)
//     d_valid/d_ready, d_bits_*    D channel in
//     rsp_*                        response out (combinational from D)
//     busy                         A stage full or any source in flight
//     proto_err                    sticky protocol-violation flag
module tl_ul_requester
  import tl_ul_pkg::*;
#(
  parameter int unsigned SOURCES = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [7:0]        cmd_mask,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [2:0]        a_bits_opcode,
  output logic [2:0]        a_bits_param,
  output logic [3:0]        a_bits_size,
  output logic [4:0]        a_bits_source,
  output logic [ADDR_W-1:0] a_bits_address,
  output logic [7:0]        a_bits_mask,
  output logic [DATA_W-1:0] a_bits_data,
  output logic              a_bits_corrupt,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [2:0]        d_bits_opcode,
  input  logic [1:0]        d_bits_param,
  input  logic [3:0]        d_bits_size,
  input  logic [4:0]        d_bits_source,
  input  logic              d_bits_sink,
  input  logic              d_bits_denied,
  input  logic [DATA_W-1:0] d_bits_data,
  input  logic              d_bits_corrupt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [4:0]        rsp_source,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              rsp_denied,
  output logic              rsp_corrupt,
  output logic              busy,
  output logic              proto_err
);

  // A stage registers
  logic                  r_a_valid;
  logic [2:0]            r_a_opcode;
  logic [3:0]            r_a_size;
  logic [SRC_W-1:0]      r_a_source;
  logic [ADDR_W-1:0]     r_a_address;
  logic [7:0]            r_a_mask;
  logic [DATA_W-1:0]     r_a_data;

  // D tracking registers
  logic [BEAT_CNT_W-1:0] r_beat_cnt;
  logic [3:0]            r_burst_size;
  logic                  r_proto_err;

  // Pool interface
  logic                  w_any_free;
  logic [SRC_W-1:0]      w_alloc_idx;
  logic [SOURCES-1:0]    w_allocated;
  logic [SOURCES-1:0]    w_kind_get;

  logic                  w_cmd_fire;
  req_kind_e             w_cmd_kind;
  logic [7:0]            w_full_mask;
  logic [2:0]            w_put_opcode;

  logic                  w_d_fire;
  logic                  w_src_alloc;
  logic                  w_src_get;
  logic                  w_is_get;
  logic [BEAT_CNT_W-1:0] w_beats;
  logic                  w_last;
  logic                  w_opc_bad;
  logic                  w_size_bad;
  logic                  w_err;
  logic                  w_free;
  logic                  w_unused;

  assign w_unused = &{1'b0, d_bits_param, d_bits_sink};

  // ---------------- A path ----------------
  assign cmd_ready    = (!r_a_valid || a_ready) && w_any_free;
  assign w_cmd_fire   = cmd_valid && cmd_ready;
  assign w_cmd_kind   = cmd_write ? KIND_PUT : KIND_GET;
  assign w_full_mask  = full_mask(cmd_size, cmd_addr[2:0]);
  assign w_put_opcode = (cmd_mask == w_full_mask) ? OP_PUT_FULL : OP_PUT_PARTIAL;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a_valid   <= 1'b0;
      r_a_opcode  <= '0;
      r_a_size    <= '0;
      r_a_source  <= '0;
      r_a_address <= '0;
      r_a_mask    <= '0;
      r_a_data    <= '0;
    end else if (w_cmd_fire) begin
      r_a_valid   <= 1'b1;
      r_a_opcode  <= cmd_write ? w_put_opcode : OP_GET;
      r_a_size    <= cmd_size;
      r_a_source  <= w_alloc_idx;
      r_a_address <= cmd_addr;
      r_a_mask    <= cmd_write ? cmd_mask : w_full_mask;
      r_a_data    <= cmd_write ? cmd_data : '0;
    end else if (a_ready) begin
      r_a_valid   <= 1'b0;
    end
  end

  tl_source_pool #(
    .SOURCES (SOURCES)
  ) u_pool (
    .clock        (clock),
    .reset        (reset),
    .i_alloc      (w_cmd_fire),
    .i_alloc_kind (w_cmd_kind),
    .i_free       (w_free),
    .i_free_idx   (d_bits_source),
    .o_any_free   (w_any_free),
    .o_alloc_idx  (w_alloc_idx),
    .o_allocated  (w_allocated),
    .o_kind_get   (w_kind_get)
  );

  // ---------------- D path ----------------
  assign w_d_fire = d_valid && rsp_ready;

  // Sources at or above SOURCES never match, so they read as unallocated.
  always_comb begin
    w_src_alloc = 1'b0;
    w_src_get   = 1'b0;
    for (int unsigned i = 0; i < SOURCES; i++) begin
      if (d_bits_source == SRC_W'(i)) begin
        w_src_alloc = w_allocated[i];
        w_src_get   = w_kind_get[i];
      end
    end
  end

  // With no recorded kind, the opcode decides whether beats carry data.
  assign w_is_get   = w_src_alloc ? w_src_get : (d_bits_opcode == OP_ACCESS_ACK_DATA);
  assign w_beats    = w_is_get ? beats_of(d_bits_size) : BEAT_CNT_W'(1);
  assign w_last     = (r_beat_cnt == (w_beats - BEAT_CNT_W'(1)));
  assign w_opc_bad  = w_src_alloc &&
                      (d_bits_opcode != (w_src_get ? OP_ACCESS_ACK_DATA : OP_ACCESS_ACK));
  assign w_size_bad = (r_beat_cnt != '0) && (d_bits_size != r_burst_size);
  assign w_err      = !w_src_alloc || w_opc_bad || w_size_bad;
  assign w_free     = w_d_fire && w_last && w_src_alloc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_beat_cnt   <= '0;
      r_burst_size <= '0;
      r_proto_err  <= 1'b0;
    end else if (w_d_fire) begin
      if (r_beat_cnt == '0) r_burst_size <= d_bits_size;
      r_beat_cnt <= w_last ? '0 : (r_beat_cnt + BEAT_CNT_W'(1));
      if (w_err) r_proto_err <= 1'b1;
    end
  end

  // ---------------- outputs ----------------
  assign a_valid        = r_a_valid;
  assign a_bits_opcode  = r_a_opcode;
  assign a_bits_param   = '0;
  assign a_bits_size    = r_a_size;
  assign a_bits_source  = r_a_source;
  assign a_bits_address = r_a_address;
  assign a_bits_mask    = r_a_mask;
  assign a_bits_data    = r_a_data;
  assign a_bits_corrupt = 1'b0;

  assign d_ready     = rsp_ready;
  assign rsp_valid   = d_valid;
  assign rsp_source  = d_bits_source;
  assign rsp_data    = d_bits_data;
  assign rsp_last    = w_last;
  assign rsp_denied  = d_bits_denied;
  assign rsp_corrupt = d_bits_corrupt;

  assign busy      = r_a_valid || (|w_allocated);
  assign proto_err = r_proto_err;

endmodule
